// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
//
// Sequencer for the operand side of one MAC block. A start request clears the
// MAC, streams N_TERMS operand pairs taken from two arithmetic sequences
// (base + k*step, mod 256), waits MAC_LAT cycles for the MAC pipeline, then
// captures MAC_OUT and offers it on a valid/ready handshake.
//
// Parameters
//   N_TERMS  operand pairs per run, 1..255
//   MAC_LAT  wait cycles between the last term and capture, 1..7
//
// Ports
//   clk           single clock, rising edge
//   aclr          synchronous active-high reset / run abort
//   start         run request, sampled only while idle
//   a_base/a_step first A operand and A increment per term
//   b_base/b_step first B operand and B increment per term
//   mac_a/mac_b   operands to the MAC
//   mac_clr       MAC clear
//   mac_out       registered MAC sum
//   busy          high whenever a run is in progress or a result is pending
//   result        captured sum, held until the next capture
//   result_valid  result available
//   result_ready  consumer accepts the result
//   mismatch/ovf  reference-check flags (MAC_FEEDER_CHECK_EN only)
//
// Build option
//   MAC_FEEDER_CHECK_EN  adds a 24-bit reference accumulator that re-sums the
//                        fed products; at capture it flags a disagreement with
//                        mac_out (mismatch) and a sum beyond 16 bits (ovf).
// -----------------------------------------------------------------------------
module mac_feeder #(
   parameter int N_TERMS = 5,
   parameter int MAC_LAT = 1
) (
   input  logic        clk,
   input  logic        aclr,
   input  logic        start,
   input  logic [7:0]  a_base,
   input  logic [7:0]  a_step,
   input  logic [7:0]  b_base,
   input  logic [7:0]  b_step,
   output logic [7:0]  mac_a,
   output logic [7:0]  mac_b,
   output logic        mac_clr,
   input  logic [15:0] mac_out,
   output logic        busy,
   output logic [15:0] result,
   output logic        result_valid,
   input  logic        result_ready
`ifdef MAC_FEEDER_CHECK_EN
   ,
   output logic        mismatch,
   output logic        ovf
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);
   localparam logic [2:0] LAST_WAIT = 3'(MAC_LAT - 1);

   state_t      state_r;
   logic [7:0]  a_cur_r;       // next A term (running adder)
   logic [7:0]  a_step_r;
   logic [7:0]  b_cur_r;       // next B term (running adder)
   logic [7:0]  b_step_r;
   logic [7:0]  term_cnt_r;    // index of the term currently on mac_a/mac_b
   logic [2:0]  wait_cnt_r;
   logic [7:0]  mac_a_r;
   logic [7:0]  mac_b_r;
   logic        mac_clr_r;
   logic        busy_r;
   logic [15:0] result_r;
   logic        result_valid_r;

`ifdef MAC_FEEDER_CHECK_EN
   logic [23:0] ref_acc_r;
   logic        mismatch_r;
   logic        ovf_r;

   // Product of the operand pair currently presented to the MAC, widened to
   // the reference accumulator width so no bits are lost before summing.
   function automatic logic [23:0] term_product(input logic [7:0] a, input logic [7:0] b);
      return 24'(a) * 24'(b);
   endfunction
`endif

   // Run sequencer: state, operand generation, capture and handshake.
   always_ff @(posedge clk) begin
      if (aclr) begin
         // Abort discards the run; mac_clr stays low, the next CLEAR cleans the MAC.
         state_r        <= ST_IDLE;
         a_cur_r        <= 8'd0;
         a_step_r       <= 8'd0;
         b_cur_r        <= 8'd0;
         b_step_r       <= 8'd0;
         term_cnt_r     <= 8'd0;
         wait_cnt_r     <= 3'd0;
         mac_a_r        <= 8'd0;
         mac_b_r        <= 8'd0;
         mac_clr_r      <= 1'b0;
         busy_r         <= 1'b0;
         result_r       <= 16'd0;
         result_valid_r <= 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
         ref_acc_r      <= 24'd0;
         mismatch_r     <= 1'b0;
         ovf_r          <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  // Latch the sequence definition; later input changes are ignored.
                  state_r   <= ST_CLEAR;
                  a_cur_r   <= a_base;
                  a_step_r  <= a_step;
                  b_cur_r   <= b_base;
                  b_step_r  <= b_step;
                  mac_clr_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end

            ST_CLEAR: begin
               // Present term 0 and pre-advance the running adders to term 1.
               state_r    <= ST_FEED;
               mac_clr_r  <= 1'b0;
               mac_a_r    <= a_cur_r;
               mac_b_r    <= b_cur_r;
               a_cur_r    <= a_cur_r + a_step_r;
               b_cur_r    <= b_cur_r + b_step_r;
               term_cnt_r <= 8'd0;
`ifdef MAC_FEEDER_CHECK_EN
               ref_acc_r  <= 24'd0;
`endif
            end

            ST_FEED: begin
`ifdef MAC_FEEDER_CHECK_EN
               // The MAC adds the presented pair on this same edge.
               ref_acc_r <= ref_acc_r + term_product(mac_a_r, mac_b_r);
`endif
               if (term_cnt_r == LAST_TERM) begin
                  // Zero operands so the MAC accumulates nothing further.
                  state_r    <= ST_WAIT;
                  mac_a_r    <= 8'd0;
                  mac_b_r    <= 8'd0;
                  wait_cnt_r <= 3'd0;
               end else begin
                  state_r    <= ST_FEED;
                  mac_a_r    <= a_cur_r;
                  mac_b_r    <= b_cur_r;
                  a_cur_r    <= a_cur_r + a_step_r;
                  b_cur_r    <= b_cur_r + b_step_r;
                  term_cnt_r <= term_cnt_r + 8'd1;
               end
            end

            ST_WAIT: begin
               if (wait_cnt_r == LAST_WAIT) begin
                  state_r        <= ST_DONE;
                  result_r       <= mac_out;
                  result_valid_r <= 1'b1;
`ifdef MAC_FEEDER_CHECK_EN
                  mismatch_r     <= (ref_acc_r[15:0] != mac_out);
                  ovf_r          <= (ref_acc_r[23:16] != 8'd0);
`endif
               end else begin
                  state_r    <= ST_WAIT;
                  wait_cnt_r <= wait_cnt_r + 3'd1;
               end
            end

            ST_DONE: begin
               // A simultaneous start is dropped; it must be reissued in IDLE.
               if (result_ready) begin
                  state_r        <= ST_IDLE;
                  result_valid_r <= 1'b0;
                  busy_r         <= 1'b0;
               end else begin
                  state_r        <= ST_DONE;
               end
            end

            default: begin
               state_r        <= ST_IDLE;
               mac_a_r        <= 8'd0;
               mac_b_r        <= 8'd0;
               mac_clr_r      <= 1'b0;
               busy_r         <= 1'b0;
               result_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign mac_a        = mac_a_r;
   assign mac_b        = mac_b_r;
   assign mac_clr      = mac_clr_r;
   assign busy         = busy_r;
   assign result       = result_r;
   assign result_valid = result_valid_r;
`ifdef MAC_FEEDER_CHECK_EN
   assign mismatch     = mismatch_r;
   assign ovf          = ovf_r;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_feeder
//
// Self-checking bench for mac_feeder. Contains a behavioural MAC (with an
// optional +1-per-edge fault) and a reference model that computes the expected
// operand sequences and sums directly from base + k*step arithmetic.
// -----------------------------------------------------------------------------
module tb_mac_feeder;

   localparam int N   = 5;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        aclr;
   logic        start;
   logic [7:0]  a_base, a_step, b_base, b_step;
   logic [7:0]  mac_a, mac_b;
   logic        mac_clr;
   logic [15:0] mac_out;
   logic        busy;
   logic [15:0] result;
   logic        result_valid;
   logic        result_ready;
`ifdef MAC_FEEDER_CHECK_EN
   logic        mismatch;
   logic        ovf;
`endif

   logic        fault;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   mac_feeder #(.N_TERMS(N), .MAC_LAT(LAT)) dut (
      .clk          (clk),
      .aclr         (aclr),
      .start        (start),
      .a_base       (a_base),
      .a_step       (a_step),
      .b_base       (b_base),
      .b_step       (b_step),
      .mac_a        (mac_a),
      .mac_b        (mac_b),
      .mac_clr      (mac_clr),
      .mac_out      (mac_out),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
`ifdef MAC_FEEDER_CHECK_EN
      ,
      .mismatch     (mismatch),
      .ovf          (ovf)
`endif
   );

   // Behavioural MAC: clear on mac_clr, otherwise accumulate (plus optional fault).
   always @(posedge clk) begin
      if (mac_clr) mac_out <= 16'd0;
      else         mac_out <= mac_out + 16'(mac_a) * 16'(mac_b) + 16'(fault);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] term(input int base, input int step, input int k);
      return 8'((base + k * step) % 256);
   endfunction

   // One complete run: start, operand stream, capture, hold, release.
   task automatic do_run(input logic [7:0] ab, input logic [7:0] as_, input logic [7:0] bb,
                         input logic [7:0] bs, input int hold);
      int sum;
      sum = 0;
      for (int k = 0; k < N; k++) sum += int'(term(ab, as_, k)) * int'(term(bb, bs, k));
      a_base = ab; a_step = as_; b_base = bb; b_step = bs;
      start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble inputs: the run must use the latched values.
      a_base = 8'($urandom); a_step = 8'($urandom);
      b_base = 8'($urandom); b_step = 8'($urandom);
      check("clear_clr", {31'd0, mac_clr}, 32'd1);
      check("clear_ops", {16'd0, mac_a, mac_b}, 32'd0);
      check("clear_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < N; k++) begin
         tick();
         check("feed_a", {24'd0, mac_a}, {24'd0, term(ab, as_, k)});
         check("feed_b", {24'd0, mac_b}, {24'd0, term(bb, bs, k)});
         check("feed_clr", {31'd0, mac_clr}, 32'd0);
         check("feed_busy", {31'd0, busy}, 32'd1);
      end
      for (int w = 0; w < LAT; w++) begin
         tick();
         check("wait_ops", {16'd0, mac_a, mac_b}, 32'd0);
         check("wait_valid", {31'd0, result_valid}, 32'd0);
      end
      tick();
      check("valid", {31'd0, result_valid}, 32'd1);
      check("result", {16'd0, result}, {16'd0, sum[15:0]});
`ifdef MAC_FEEDER_CHECK_EN
      check("ovf", {31'd0, ovf}, {31'd0, (sum > 65535)});
      check("mismatch", {31'd0, mismatch}, {31'd0, fault});
`endif
      for (int h = 0; h < hold; h++) begin
         start = 1'($urandom);
         tick();
         check("hold_valid", {31'd0, result_valid}, 32'd1);
         check("hold_result", {16'd0, result}, {16'd0, sum[15:0]});
         check("hold_busy", {31'd0, busy}, 32'd1);
      end
      // start together with ready: only the return to IDLE happens.
      start = 1'b1;
      result_ready = 1'b1;
      tick();
      start = 1'b0;
      result_ready = 1'b0;
      check("release_valid", {31'd0, result_valid}, 32'd0);
      check("release_busy", {31'd0, busy}, 32'd0);
      check("release_result", {16'd0, result}, {16'd0, sum[15:0]});
      tick();
      check("idle_no_run", {30'd0, busy, mac_clr}, 32'd0);
   endtask

   initial begin
      int hits[$];
      int vcount;
      aclr = 1'b1; start = 1'b0; result_ready = 1'b0; fault = 1'b0;
      a_base = 8'd0; a_step = 8'd0; b_base = 8'd0; b_step = 8'd0;
      tick();
      tick();
      check("rst_ops", {16'd0, mac_a, mac_b}, 32'd0);
      check("rst_clr", {31'd0, mac_clr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
`ifdef MAC_FEEDER_CHECK_EN
      check("rst_flags", {30'd0, mismatch, ovf}, 32'd0);
`endif
      aclr = 1'b0;
      tick();

      // Directed cases from the test plan (result 0x0064, 0xF605, wrap).
      do_run(8'd2, 8'd1, 8'd0, 8'd2, 10);
      do_run(8'd255, 8'd0, 8'd255, 8'd0, 0);
      do_run(8'h80, 8'h80, 8'h80, 8'h80, 1);

      // Abort during FEED k=2, then a clean run.
      a_base = 8'($urandom); a_step = 8'($urandom);
      b_base = 8'($urandom); b_step = 8'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      aclr = 1'b1;
      tick();
      aclr = 1'b0;
      check("abort_ops", {16'd0, mac_a, mac_b}, 32'd0);
      check("abort_ctl", {29'd0, mac_clr, busy, result_valid}, 32'd0);
      vcount = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (result_valid) vcount++;
      end
      check("abort_no_valid", 32'(vcount), 32'd0);
      do_run(8'd7, 8'd3, 8'd11, 8'd5, 2);

      // Randomized runs.
      for (int r = 0; r < 8; r++)
         do_run(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

      // Back-to-back throughput with start and ready held high.
      start = 1'b1;
      result_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (result_valid) hits.push_back(c);
      end
      start = 1'b0;
      check("tput_runs", {31'd0, (hits.size() >= 2)}, 32'd1);
      if (hits.size() >= 2) check("tput_period", 32'(hits[1] - hits[0]), 32'(N + LAT + 3));
      for (int c = 0; c < 20; c++) tick();
      result_ready = 1'b0;
      check("tput_drain_busy", {31'd0, busy}, 32'd0);

`ifdef MAC_FEEDER_CHECK_EN
      // Faulted MAC: reference must disagree at capture.
      fault = 1'b1;
      do_run(8'd2, 8'd1, 8'd0, 8'd2, 0);
      fault = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Sequencer that drives the operand side of the codebase `MAC` block and collects its result. On `start` it clears the MAC, streams `N_TERMS` operand pairs from two arithmetic sequences (`base + k*step`, mod 256), waits for the MAC pipeline and captures `MAC_OUT`. It then presents the result with a valid/ready handshake. It sits between a control/host register block and one `MAC` instance.

## Interface
- `N_TERMS`, default 5: operand pairs per run, 1..255.
- `MAC_LAT`, default 1: wait cycles after the last term before capture, 1..7.
- `clk` in 1: single clock; all logic on the rising edge.
- `aclr` in 1: reset, synchronous, active-high.
- `start` in 1: run request; sampled only in IDLE.
- `a_base` in 8: first A operand.
- `a_step` in 8: A increment per term.
- `b_base` in 8: first B operand.
- `b_step` in 8: B increment per term.
- `mac_a` out 8: to `MAC.A`.
- `mac_b` out 8: to `MAC.B`.
- `mac_clr` out 1: to the MAC clear input.
- `mac_out` in 16: from `MAC.MAC_OUT`.
- `busy` out 1: high in every state except IDLE.
- `result` out 16: captured sum.
- `result_valid` out 1: result is held and available.
- `result_ready` in 1: consumer accepts the result.
- `mismatch` out 1: present only with `MAC_FEEDER_CHECK_EN`.
- `ovf` out 1: present only with `MAC_FEEDER_CHECK_EN`.

## Operation
- MAC contract:
  - An edge with `mac_clr`=1 sets the sum to 0.
  - Every other edge adds `mac_a*mac_b`.
  - `mac_out` is the registered 16-bit sum, mod 2^16.
- FSM states: IDLE, CLEAR, FEED, WAIT, DONE.
- IDLE:
  - `mac_a`=`mac_b`=0 and `mac_clr`=0.
  - `start`=1 moves to CLEAR and latches base/step into internal registers.
  - Input changes after that edge have no effect on the run.
- CLEAR: one cycle with `mac_clr`=1 and `mac_a`=`mac_b`=0, then FEED with k=0.
- FEED:
  - Lasts `N_TERMS` cycles.
  - In cycle k: `mac_a` = a_base + k*a_step mod 256 and `mac_b` = b_base + k*b_step mod 256.
  - Implemented as running adders, not multipliers.
  - Goes to WAIT after k = `N_TERMS`-1.
- WAIT:
  - Lasts `MAC_LAT` cycles with `mac_a`=`mac_b`=0, so no further accumulation occurs.
  - On the last WAIT edge: `result` <= `mac_out` and `result_valid` <= 1; go to DONE.
- DONE:
  - `result` and `result_valid` are held.
  - An edge with `result_ready`=1 clears `result_valid` and moves to IDLE.
  - `result` keeps its value until the next capture.
- `start` outside IDLE is ignored; there is no queuing.
- `start` and `result_ready` on the same edge in DONE: return to IDLE only. The new `start` must be reissued.

## Timing
- Reset values: state IDLE; `mac_a`, `mac_b`, `mac_clr`, `busy`, `result`, `result_valid`, `mismatch`, `ovf` all 0.
- `aclr` mid-run (any state):
  - Abort at the next edge; the run is discarded and nothing is captured.
  - `mac_clr` is not asserted by the abort itself.
  - The next run's CLEAR cleans the MAC.
- `aclr` has priority over `start` and `result_ready`.
- Latency, counting from the edge that samples `start` (edge 0):
  - `mac_clr` high between edges 0 and 1.
  - Terms are applied between edges 1..`N_TERMS`+1.
  - `result_valid` rises at edge `N_TERMS`+1+`MAC_LAT`.
  - Defaults: edge 7.
- Throughput: back-to-back runs take `N_TERMS`+`MAC_LAT`+3 cycles each when `result_ready` is tied high.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `MAC_FEEDER_CHECK_EN`.
- Defined:
  - Adds an internal 24-bit reference accumulator, cleared in CLEAR, summing the same operand products during FEED.
  - At capture, `mismatch` <= (ref[15:0] != `mac_out`).
  - At capture, `ovf` <= (ref[23:16] != 0).
  - Both flags are held with `result`.
- Not defined: `mismatch` and `ovf` ports are absent; no reference logic is generated.

## Test plan
- Defaults; a_base=2, a_step=1, b_base=0, b_step=2; pulse `start`:
  - `mac_a`/`mac_b` sequence: 2/0, 3/2, 4/4, 5/6, 6/8.
  - `result`=0x0064 with `result_valid` at edge 7.
  - With CHECK: `mismatch`=0, `ovf`=0.
- a_base=b_base=255, steps 0, N_TERMS=5:
  - `result`=0xF605.
  - With CHECK: `ovf`=1, `mismatch`=0.
- Steps 0x80, bases 0x80, N_TERMS=3:
  - Operands wrap: 0x80, 0x00, 0x80.
  - `result`=0x8000.
- `result_ready` held low 10 cycles after valid:
  - `result` and `result_valid` stable; `busy`=1.
  - `start` pulses are ignored.
  - Ready then drops valid next edge, and IDLE is reached.
- `aclr` for one edge during FEED k=2:
  - All outputs 0 next cycle; no `result_valid` ever for that run.
  - A following run produces a correct sum.
- With CHECK, MAC model faulted to add +1 per edge: `mismatch`=1 at capture.
